ba201v32i_ifu: RTL and testbench
================================

Name: ba201v32i_ifu

Overview:
- Instruction fetch unit: the initiator side of the instruction-memory read port. It issues word addresses, captures the returned instruction words, and buffers {pc, instr} pairs in a small FIFO for decode.
- Sits between the core's redirect logic (branch, jump, trap) and the instruction memory.
- Hands instructions to decode through a valid/ready handshake.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, number of buffered {pc, instr} entries; power of 2, minimum 2.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- ifu_o_itim_valid  output  1  read request to instruction memory this cycle.
- ifu_o_itim_addr  output  32  byte address of the request; bits [1:0] always 0.
- ifu_i_itim_rdata  input  32  instruction word returned by instruction memory.
- ifu_i_redirect  input  1  flush and restart fetch at the target.
- ifu_i_redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0.
- ifu_o_valid  output  1  FIFO head holds a valid instruction.
- ifu_o_pc  output  32  PC of the FIFO head.
- ifu_o_instr  output  32  instruction word of the FIFO head.
- ifu_i_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low on rst_n; clock port is clk.
  - While rst_n=0: fetch_pc<=RESET_VECTOR, FIFO count=0, inflight=0.
  - Outputs during reset: ifu_o_valid=0, ifu_o_itim_valid=0, ifu_o_pc=0, ifu_o_instr=0.
- Request rule:
  - ifu_o_itim_valid=1 when (count + inflight) < FIFO_DEPTH and ifu_i_redirect=0.
  - count and inflight are registered, so there is no combinational path from ifu_i_ready to ifu_o_itim_valid.
  - ifu_o_itim_addr = fetch_pc.
  - fetch_pc advances by 4 on every issued request; it wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- Response (default build, combinational memory):
  - rdata is valid in the same cycle as the request.
  - {fetch_pc, rdata} is pushed into the FIFO at that edge; inflight is always 0.
- Output handshake:
  - ifu_o_valid = (count != 0); pc and instr come from the FIFO head register array.
  - Pop when ifu_o_valid && ifu_i_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Head stays stable while valid=1 and ready=0.
- Latency and throughput:
  - First request in the first cycle after rst_n rises.
  - ifu_o_valid rises one cycle later.
  - Sustained throughput is 1 instr/cycle with ready held high.
- Full: no request is issued when count + inflight == FIFO_DEPTH. No data is lost and fetch_pc is held.
- Redirect (priority over everything):
  - Same edge: FIFO flushed (count=0), any pending pop discarded, fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No request is issued in the redirect cycle.
  - Next cycle: ifu_o_valid=0 and a request is issued at the target.
  - Back-to-back redirects: the last one wins.
- Reset asserted mid-operation: all state reverts at that edge; an in-flight response is discarded.

Optional Feature:
- Macro: IFU_SYNC_ITIM_EN.
- When defined, instruction memory is a registered block ROM: rdata for a request issued in cycle N is valid in cycle N+1.
  - A 1-bit inflight register plus an inflight_pc register track the outstanding request.
  - The response is pushed in cycle N+1.
  - Redirect in cycle N or N+1 sets a drop flag, so the returning word is discarded and not pushed.
  - Full throughput requires FIFO_DEPTH >= 4.
  - Observable latency is request-to-ifu_o_valid = 2 cycles.
- When not defined: combinational memory, inflight tied to 0, no drop logic.

Decomposition:
- Shared package/header holds:
  - INSTR_WORD_BYTES=4.
  - Default RESET_VECTOR.
  - NOP encoding 32'h0000_0013, used only by benches.
  - FIFO entry layout {pc[31:0], instr[31:0]} as a 64-bit constant width.
- One natural sub-module: ba201v32i_ifu_fifo.
  - Parameterised synchronous FIFO with push, pop, flush, count, head.
  - Flush takes priority over push and pop.

Test Plan:
- Reset release, RESET_VECTOR=0, memory holds word k at address 4k, ready=1 -> requests at 0x0,0x4,0x8,...; ifu_o_valid rises 1 cycle after reset; decode sees (0x0,w0),(0x4,w1),(0x8,w2) on consecutive cycles.
- ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 requests (0x0..0xC), then itim_valid=0. Raise ready -> pc sequence 0x0,0x4,0x8,0xC,0x10 with no gap or duplicate.
- Redirect to 0x0000_0103 while FIFO holds 3 entries and ready=1 -> that edge pops nothing, next cycle ifu_o_valid=0 and addr=0x100, the following cycle head pc=0x100.
- Wrap: redirect to 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; head pcs match in order.
- With IFU_SYNC_ITIM_EN: redirect to 0x200 the cycle after a request to 0x40 -> word from 0x40 never appears; first output pc=0x200 two cycles after its request.
- Assert rst_n=0 for 1 cycle with a full FIFO -> ifu_o_valid=0 next cycle; fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/ba201v32i_ifu_pkg.sv
// ba201v32i_ifu_pkg: shared constants and {pc, instr} entry layout for the IFU.
// Optional build macro IFU_SYNC_ITIM_EN selects a registered instruction memory.
package ba201v32i_ifu_pkg;

  localparam int unsigned INSTR_WORD_BYTES = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned ENTRY_W          = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifu_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/ba201v32i_ifu_if.sv
// ba201v32i_ifu_if: instruction-memory, redirect and decode signals of the IFU.
// master = IFU side, slave = memory/core/decode side.
interface ba201v32i_ifu_if;

  logic        ifu_o_itim_valid;
  logic [31:0] ifu_o_itim_addr;
  logic [31:0] ifu_i_itim_rdata;
  logic        ifu_i_redirect;
  logic [31:0] ifu_i_redirect_pc;
  logic        ifu_o_valid;
  logic [31:0] ifu_o_pc;
  logic [31:0] ifu_o_instr;
  logic        ifu_i_ready;

  modport master (
    output ifu_o_itim_valid,
    output ifu_o_itim_addr,
    input  ifu_i_itim_rdata,
    input  ifu_i_redirect,
    input  ifu_i_redirect_pc,
    output ifu_o_valid,
    output ifu_o_pc,
    output ifu_o_instr,
    input  ifu_i_ready
  );

  modport slave (
    input  ifu_o_itim_valid,
    input  ifu_o_itim_addr,
    output ifu_i_itim_rdata,
    output ifu_i_redirect,
    output ifu_i_redirect_pc,
    input  ifu_o_valid,
    input  ifu_o_pc,
    input  ifu_o_instr,
    output ifu_i_ready
  );

endinterface

// File: rtl/ba201v32i_ifu_fifo.sv
// ba201v32i_ifu_fifo: synchronous {pc, instr} FIFO with push, pop and flush.
// Flush wins over push and pop; caller never pushes when full.
module ba201v32i_ifu_fifo
  import ba201v32i_ifu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  ifu_entry_t    i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output ifu_entry_t    o_head
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [CW-1:0]      r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (i_pop)  r_rp <= r_rp + AW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = ifu_entry_t'(r_mem[r_rp]);

endmodule

// File: rtl/ba201v32i_ifu.sv
// ba201v32i_ifu: issues word fetches and queues {pc, instr} pairs for decode.
// Define IFU_SYNC_ITIM_EN when instruction memory returns data one cycle late.
module ba201v32i_ifu
  import ba201v32i_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic             clk,
  input logic             rst_n,
  ba201v32i_ifu_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ;
  logic          w_inflight;
  logic          w_req;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  ifu_entry_t    w_push_data;
  ifu_entry_t    w_head;

  // Occupancy uses registered state only, so ready never reaches itim_valid.
  assign w_occ   = w_count + CW'(w_inflight);
  assign w_req   = rst_n & ~bus.ifu_i_redirect & (w_occ < DEPTH_C);
  assign w_valid = rst_n & (w_count != '0);
  assign w_pop   = w_valid & bus.ifu_i_ready;

`ifdef IFU_SYNC_ITIM_EN
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        w_drop;

  // A redirect while the word is returning discards it.
  assign w_drop      = bus.ifu_i_redirect;
  assign w_inflight  = r_inflight;
  assign w_push      = r_inflight & ~w_drop;
  assign w_push_data = '{pc: r_inflight_pc,
                         instr: bus.ifu_i_itim_rdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_VECTOR;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_inflight_pc <= r_fetch_pc;
    end
  end
`else
  assign w_inflight  = 1'b0;
  assign w_push      = w_req;
  assign w_push_data = '{pc: r_fetch_pc,
                         instr: bus.ifu_i_itim_rdata};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_VECTOR;
    end else if (bus.ifu_i_redirect) begin
      r_fetch_pc <= align_pc(bus.ifu_i_redirect_pc);
    end else if (w_req) begin
      r_fetch_pc <= r_fetch_pc + 32'(INSTR_WORD_BYTES);
    end
  end

  ba201v32i_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (bus.ifu_i_redirect),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.ifu_o_itim_valid = w_req;
  assign bus.ifu_o_itim_addr  = r_fetch_pc;
  assign bus.ifu_o_valid      = w_valid;
  assign bus.ifu_o_pc         = w_valid ? w_head.pc : '0;
  assign bus.ifu_o_instr      = w_valid ? w_head.instr : '0;

endmodule

// File: tb/tb_ba201v32i_ifu.sv
// tb_ba201v32i_ifu: directed + random bench for the IFU against a queue model.
// Build with IFU_SYNC_ITIM_EN to exercise the registered-memory variant.
module tb_ba201v32i_ifu;
  import ba201v32i_ifu_pkg::*;

  localparam int DEPTH = 4;
`ifdef IFU_SYNC_ITIM_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errs   = 0;
  int   n_req;

  ba201v32i_ifu_if bus();

  ba201v32i_ifu #(
    .RESET_VECTOR (32'h0),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word k sits at byte address 4k; page 0x100 holds NOPs.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:8] == 24'h000001) return NOP_INSTR;
    return {2'b00, a[31:2]} ^ 32'h1357_9BDF;
  endfunction

`ifdef IFU_SYNC_ITIM_EN
  always @(posedge clk)
    bus.ifu_i_itim_rdata <= mem_word(bus.ifu_o_itim_addr);
`else
  assign bus.ifu_i_itim_rdata = mem_word(bus.ifu_o_itim_addr);
`endif

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm,
                      input logic act,
                      input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: decoded-order queue of fetched pcs plus one pending fetch.
  logic [31:0] m_q[$];
  logic [31:0] m_fetch   = 32'h0;
  bit          m_pend    = 1'b0;
  logic [31:0] m_pend_pc = 32'h0;

  initial begin
    bit          e_itim;
    bit          e_valid;
    logic [31:0] e_pc;
    forever begin
      @(negedge clk);
      e_itim = rst_n && !bus.ifu_i_redirect &&
               ((m_q.size() + int'(m_pend)) < DEPTH);
      e_valid = rst_n && (m_q.size() != 0);
      e_pc = e_valid ? m_q[0] : 32'h0;
      chkb("itim_valid", bus.ifu_o_itim_valid, e_itim);
      if (e_itim)
        chk("itim_addr", bus.ifu_o_itim_addr, m_fetch);
      chkb("o_valid", bus.ifu_o_valid, e_valid);
      chk("o_pc", bus.ifu_o_pc, e_pc);
      chk("o_instr", bus.ifu_o_instr,
          e_valid ? mem_word(e_pc) : 32'h0);
      if (!rst_n) begin
        m_q.delete();
        m_fetch = 32'h0;
        m_pend  = 1'b0;
      end else if (bus.ifu_i_redirect) begin
        m_q.delete();
        m_fetch = bus.ifu_i_redirect_pc & 32'hFFFF_FFFC;
        m_pend  = 1'b0;
      end else begin
        if (e_valid && bus.ifu_i_ready)
          void'(m_q.pop_front());
`ifdef IFU_SYNC_ITIM_EN
        if (m_pend) m_q.push_back(m_pend_pc);
        m_pend    = e_itim;
        m_pend_pc = m_fetch;
`else
        if (e_itim) m_q.push_back(m_fetch);
`endif
        if (e_itim) m_fetch = m_fetch + 32'd4;
      end
    end
  end

  initial begin
    rst_n                 = 1'b0;
    bus.ifu_i_ready       = 1'b0;
    bus.ifu_i_redirect    = 1'b0;
    bus.ifu_i_redirect_pc = 32'h0;
    repeat (3) tick();
    #3;
    chkb("rst_valid", bus.ifu_o_valid, 1'b0);
    chkb("rst_itim", bus.ifu_o_itim_valid, 1'b0);
    chk("rst_pc", bus.ifu_o_pc, 32'h0);
    chk("rst_instr", bus.ifu_o_instr, 32'h0);

    // Stall from reset: exactly DEPTH requests.
    tick();
    rst_n = 1'b1;
    #3;
    chkb("first_req", bus.ifu_o_itim_valid, 1'b1);
    chk("first_addr", bus.ifu_o_itim_addr, 32'h0);
    n_req = 1;
    repeat (9) begin
      tick();
      #3;
      n_req += int'(bus.ifu_o_itim_valid);
    end
    chk("full_reqs", 32'(n_req), 32'd4);
    chkb("full_stall", bus.ifu_o_itim_valid, 1'b0);
    chk("hold_pc", bus.ifu_o_pc, 32'h0);
    chk("hold_instr", bus.ifu_o_instr, 32'h1357_9BDF);

    tick();
    bus.ifu_i_ready = 1'b1;
    #3;
    chk("drain_pc0", bus.ifu_o_pc, 32'h0);
    tick();
    #3;
    chk("drain_pc1", bus.ifu_o_pc, 32'h4);
    chk("drain_instr1", bus.ifu_o_instr, 32'h1357_9BDE);
    repeat (6) tick();

    // Fill, then a one-cycle reset with the FIFO full.
    bus.ifu_i_ready = 1'b0;
    repeat (8) tick();
    #3;
    chkb("refill_stall", bus.ifu_o_itim_valid, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #3;
    chkb("rst_mid_valid", bus.ifu_o_valid, 1'b0);
    chkb("rst_mid_req", bus.ifu_o_itim_valid, 1'b1);
    chk("rst_mid_addr", bus.ifu_o_itim_addr, 32'h0);

    // Redirect with three entries held and ready high.
    repeat (2 + LAT) tick();
    bus.ifu_i_ready       = 1'b1;
    bus.ifu_i_redirect    = 1'b1;
    bus.ifu_i_redirect_pc = 32'h0000_0103;
    #3;
    chk("redir_depth", 32'(m_q.size()), 32'd3);
    chkb("redir_noreq", bus.ifu_o_itim_valid, 1'b0);
    tick();
    bus.ifu_i_redirect = 1'b0;
    #3;
    chkb("redir_valid0", bus.ifu_o_valid, 1'b0);
    chkb("redir_req", bus.ifu_o_itim_valid, 1'b1);
    chk("redir_addr", bus.ifu_o_itim_addr, 32'h100);
    repeat (LAT) tick();
    #3;
    chk("redir_head_pc", bus.ifu_o_pc, 32'h100);
    chk("redir_head_instr", bus.ifu_o_instr, 32'h13);

    // Address wrap.
    tick();
    bus.ifu_i_redirect    = 1'b1;
    bus.ifu_i_redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.ifu_i_redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #3;
      chk("wrap_addr", bus.ifu_o_itim_addr,
          32'hFFFF_FFF8 + 32'(4 * k));
      if (k >= LAT)
        chk("wrap_pc", bus.ifu_o_pc,
            32'hFFFF_FFF8 + 32'(4 * (k - LAT)));
    end

    // Redirect right after a fetch of 0x40.
    tick();
    bus.ifu_i_redirect    = 1'b1;
    bus.ifu_i_redirect_pc = 32'h40;
    tick();
    bus.ifu_i_redirect = 1'b0;
    #3;
    chk("f_addr40", bus.ifu_o_itim_addr, 32'h40);
    tick();
    bus.ifu_i_redirect    = 1'b1;
    bus.ifu_i_redirect_pc = 32'h200;
    #3;
`ifdef IFU_SYNC_ITIM_EN
    chkb("drop_valid", bus.ifu_o_valid, 1'b0);
`endif
    tick();
    bus.ifu_i_redirect = 1'b0;
    #3;
    chkb("f_valid0", bus.ifu_o_valid, 1'b0);
    chk("f_addr200", bus.ifu_o_itim_addr, 32'h200);
    repeat (LAT) tick();
    #3;
    chk("f_pc200", bus.ifu_o_pc, 32'h200);

    repeat (3000) begin
      tick();
      rst_n = ($urandom_range(0, 99) != 0);
      bus.ifu_i_redirect = ($urandom_range(0, 15) == 0);
      bus.ifu_i_redirect_pc =
        ($urandom_range(0, 3) == 0) ?
        (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) :
        32'($urandom);
      bus.ifu_i_ready = ($urandom_range(0, 9) < 7);
    end
    tick();
    rst_n              = 1'b1;
    bus.ifu_i_redirect = 1'b0;
    repeat (3) tick();
    #10;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
